muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU.
- Replaces same-cycle HI/LO arithmetic with a parametrised, handshaked, signed/unsigned iterative engine.
- Adds MTHI/MTLO writes, a divide-by-zero flag and an optional single-cycle multiply mode.
- Pipeline control stalls on busy and consumes hi/lo for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with architectural HI/LO registers.
// Single-cycle ops (MTHI/MTLO, fast multiply, divide-by-zero, reserved) commit one edge after acceptance.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic                pend_q, pend_d;
  logic [2:0]          pend_op_q, pend_op_d;
  logic [XLEN-1:0]     pend_a_q, pend_a_d;
  logic [XLEN-1:0]     pend_b_q, pend_b_d;

  // Operand decode for a request arriving in IDLE
  logic            is_mul_op, is_div_op, signed_op, rt_zero;
  logic            a_neg, b_neg, launch, single;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rt_zero   = (rt == '0);
  assign a_neg     = signed_op & rs[XLEN-1];
  assign b_neg     = signed_op & rt[XLEN-1];
  assign mag_a     = a_neg ? -rs : rs;
  assign mag_b     = b_neg ? -rt : rt;
  assign launch    = start && (state_q == IDLE) &&
                     ((is_mul_op && (FAST_MUL == 0)) || (is_div_op && !rt_zero));
  assign single    = start && (state_q == IDLE) && !launch;

  // One shift-add step: acc holds {partial product, remaining multiplier bits}
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);

  // One restoring-divide step: acc holds {remainder, remaining dividend / quotient bits}
  logic [XLEN:0]   trial, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_new;
  assign trial   = acc_q[2*XLEN-1:XLEN-1];
  assign diff    = trial - {1'b0, opb_q};
  assign q_bit   = ~diff[XLEN];
  assign rem_new = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

  // Sign-extended operands make one modular product correct for both MULT and MULTU
  logic              pend_signed;
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  assign pend_signed = (pend_op_q == OP_MULT);
  assign ext_a       = {{XLEN{pend_signed & pend_a_q[XLEN-1]}}, pend_a_q};
  assign ext_b       = {{XLEN{pend_signed & pend_b_q[XLEN-1]}}, pend_b_q};
  assign fast_prod   = ext_a * ext_b;

  logic [XLEN-1:0] quo, rem;
  assign quo = acc_q[XLEN-1:0];
  assign rem = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    pend_d    = 1'b0;
    pend_op_d = pend_op_q;
    pend_a_d  = pend_a_q;
    pend_b_d  = pend_b_q;

    if (pend_q) begin
      done_d = 1'b1;
      case (pend_op_q)
        OP_MTHI: hi_d = pend_a_q;
        OP_MTLO: lo_d = pend_a_q;
        OP_MULT, OP_MULTU: begin
          if (FAST_MUL != 0) begin
            hi_d = fast_prod[2*XLEN-1:XLEN];
            lo_d = fast_prod[XLEN-1:0];
          end
        end
        OP_DIV, OP_DIVU: dbz_d = 1'b1;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          cnt_d     = '0;
          is_div_d  = is_div_op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (is_div_op) begin
            acc_d = {{XLEN{1'b0}}, mag_a};
            opb_d = mag_b;
          end else begin
            acc_d = {{XLEN{1'b0}}, mag_b};
            opb_d = mag_a;
          end
          state_d = CALC;
        end else if (single) begin
          pend_d    = 1'b1;
          pend_op_d = op;
          pend_a_d  = rs;
          pend_b_d  = rt;
        end
      end
      CALC: begin
        if (is_div_q) acc_d = {rem_new, acc_q[XLEN-2:0], q_bit};
        else          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign
        if (is_div_q) acc_d = {neg_rem_q ? -rem : rem, neg_res_q ? -quo : quo};
        else          acc_d = neg_res_q ? -acc_q : acc_q;
        state_d = FIN;
      end
      FIN: begin
        hi_d    = acc_q[2*XLEN-1:XLEN];
        lo_d    = acc_q[XLEN-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_op_q <= '0;
      pend_a_q  <= '0;
      pend_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      pend_q    <= pend_d;
      pend_op_q <= pend_op_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: iterative instance and fast-multiply instance, table vectors,
// randomized ops against an arithmetic reference model, and a reset-abort sequence.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start_s = 1'b0, start_f = 1'b0;
  logic [2:0]  op_s = '0, op_f = '0;
  logic [31:0] rs_s = '0, rt_s = '0, rs_f = '0, rt_f = '0;
  logic        busy_s, done_s, dbz_s, busy_f, done_f, dbz_f;
  logic [31:0] hi_s, lo_s, hi_f, lo_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi_s = '0, m_lo_s = '0, m_hi_f = '0, m_lo_f = '0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(0)) dut_s (
    .CLK(CLK), .RST(RST), .start(start_s), .op(op_s), .rs(rs_s), .rt(rt_s),
    .busy(busy_s), .done(done_s), .div_by_zero(dbz_s), .hi(hi_s), .lo(lo_s)
  );

  muldiv_unit #(.XLEN(XLEN), .FAST_MUL(1)) dut_f (
    .CLK(CLK), .RST(RST), .start(start_f), .op(op_f), .rs(rs_f), .rt(rt_f),
    .busy(busy_f), .done(done_f), .div_by_zero(dbz_f), .hi(hi_f), .lo(lo_f)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definition of each op
  function automatic void model(input bit fast, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] h0, input logic [31:0] l0,
                                output logic [31:0] h, output logic [31:0] l,
                                output logic d, output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    h = h0; l = l0; d = 1'b0; lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; {h, l} = p; lat = fast ? 1 : LAT; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {h, l} = p; lat = fast ? 1 : LAT; end
      3'd2: begin
        if (b == 32'd0) d = 1'b1;
        else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; lat = LAT; end
      end
      3'd3: begin
        if (b == 32'd0) d = 1'b1;
        else begin l = a / b; h = a % b; lat = LAT; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input bit fast, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit busy_all, output bit busy_any);
    bit bz;
    if (fast) begin op_f = o; rs_f = a; rt_f = b; start_f = 1'b1; end
    else      begin op_s = o; rs_s = a; rt_s = b; start_s = 1'b1; end
    @(posedge CLK); #1;
    // Scramble operands after acceptance: they must already be latched
    if (fast) begin start_f = 1'b0; rs_f = $urandom; rt_f = $urandom; end
    else      begin start_s = 1'b0; rs_s = $urandom; rt_s = $urandom; end
    cyc = 0; busy_all = 1'b1; busy_any = 1'b0;
    while (!(fast ? done_f : done_s) && cyc < 200) begin
      bz = fast ? busy_f : busy_s;
      busy_all &= bz;
      busy_any |= bz;
      @(posedge CLK); #1;
      cyc++;
    end
    if (cyc >= 200) cyc = -1;
  endtask

  task automatic exec(input bit fast, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input logic ed, input int elat,
                      input string tag);
    int cyc;
    bit ball, bany;
    logic [31:0] ah, al;
    logic ad, abusy;
    run_op(fast, o, a, b, cyc, ball, bany);
    ah = fast ? hi_f : hi_s;
    al = fast ? lo_f : lo_s;
    ad = fast ? dbz_f : dbz_s;
    abusy = fast ? busy_f : busy_s;
    $display("%s fast=%0d op=%0d rs=%h rt=%h -> hi=%h lo=%h dbz=%0d lat=%0d", tag, fast, o, a, b, ah, al, ad, cyc);
    check({tag, ".lat"}, 64'(cyc), 64'(elat));
    check({tag, ".hi"}, 64'(ah), 64'(eh));
    check({tag, ".lo"}, 64'(al), 64'(el));
    check({tag, ".dbz"}, 64'(ad), 64'(ed));
    check({tag, ".busy_at_done"}, 64'(abusy), 64'(1'b0));
    if (elat > 1) check({tag, ".busy_during"}, 64'(ball), 64'(1'b1));
    else          check({tag, ".busy_during"}, 64'(bany), 64'(1'b0));
  endtask

  task automatic rand_ops(input bit fast, input int n);
    logic [2:0]  o;
    logic [31:0] a, b, eh, el;
    logic        ed;
    int          elat;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (fast) begin
        model(1'b1, o, a, b, m_hi_f, m_lo_f, eh, el, ed, elat);
        exec(1'b1, o, a, b, eh, el, ed, elat, "rand");
        m_hi_f = eh; m_lo_f = el;
      end else begin
        model(1'b0, o, a, b, m_hi_s, m_lo_s, eh, el, ed, elat);
        exec(1'b0, o, a, b, eh, el, ed, elat, "rand");
        m_hi_s = eh; m_lo_s = el;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done, busy_mid;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, LAT};
    vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b0, LAT};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT};
    vecs[3] = '{3'd3, 32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0, LAT};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, LAT};
    vecs[5] = '{3'd4, 32'h0000_1234, 32'd9,         32'h0000_1234, 32'h8000_0000, 1'b0, 1};
    vecs[6] = '{3'd5, 32'h0000_5678, 32'd9,         32'h0000_1234, 32'h0000_5678, 1'b0, 1};
    vecs[7] = '{3'd3, 32'd7,         32'd0,         32'h0000_1234, 32'h0000_5678, 1'b1, 1};
    vecs[8] = '{3'd6, 32'h0000_AAAA, 32'd1,         32'h0000_1234, 32'h0000_5678, 1'b0, 1};
    vecs[9] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT};

    // Reset state
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.hi", 64'(hi_s), 64'(0));
    check("reset.lo", 64'(lo_s), 64'(0));
    check("reset.busy", 64'(busy_s), 64'(0));
    check("reset.done", 64'(done_s), 64'(0));
    check("reset.dbz", 64'(dbz_s), 64'(0));
    check("reset_f.hi", 64'(hi_f), 64'(0));
    check("reset_f.busy", 64'(busy_f), 64'(0));
    RST = 1'b1;

    // Table vectors, issued back to back on the iterative instance
    for (int i = 0; i < 10; i++)
      exec(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat,
           $sformatf("vec%0d", i));
    m_hi_s = vecs[9].hi;
    m_lo_s = vecs[9].lo;

    // Fast-multiply instance: single-cycle products
    exec(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1, "fmult");
    exec(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 1, "fmultu");
    m_hi_f = 32'h0000_0002;
    m_lo_f = 32'hFFFF_FFFA;

    rand_ops(1'b0, 60);
    rand_ops(1'b1, 40);

    // Abort: MULT in flight, ignored DIV start, then reset mid-operation
    exec(1'b0, 3'd4, 32'hDEAD, 32'd0, 32'hDEAD, m_lo_s, 1'b0, 1, "pre_mthi");
    exec(1'b0, 3'd5, 32'hBEEF, 32'd0, 32'hDEAD, 32'hBEEF, 1'b0, 1, "pre_mtlo");
    op_s = 3'd0; rs_s = 32'h1234_5678; rt_s = 32'd9; start_s = 1'b1;
    @(posedge CLK); #1;
    start_s = 1'b0;
    saw_done = 1'b0;
    busy_mid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin op_s = 3'd2; rs_s = 32'd100; rt_s = 32'd7; start_s = 1'b1; end
      if (c == 6) start_s = 1'b0;
      if (c == 10) RST = 1'b0;
      @(posedge CLK); #1;
      if (done_s) saw_done = 1'b1;
      if (c == 9) busy_mid = busy_s;
    end
    $display("abort: reset applied mid-MULT, hi=%h lo=%h busy=%0d", hi_s, lo_s, busy_s);
    check("abort.busy_before_reset", 64'(busy_mid), 64'(1));
    check("abort.no_done_before_reset", 64'(saw_done), 64'(0));
    check("abort.hi", 64'(hi_s), 64'(0));
    check("abort.lo", 64'(lo_s), 64'(0));
    check("abort.busy", 64'(busy_s), 64'(0));
    check("abort.done", 64'(done_s), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(posedge CLK); #1;
      if (done_s || busy_s) saw_done = 1'b1;
    end
    check("abort.stays_idle", 64'(saw_done), 64'(0));
    exec(1'b0, 3'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, LAT, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
